dm_cache_ctrl: RTL and testbench
================================

# dm_cache_ctrl

Controller for the direct-mapped, 16-words-per-line cache data array. Accepts one CPU read/write at a time, owns the tag/valid store, and performs the hit/miss lookup. On a read miss it refills the full line word-by-word from main memory. Writes are write-through, no-write-allocate. The controller sits between the CPU port, the cache data array (fill and word-write ports) and the main memory port.

## Interface
- INDEX_W, 8, index bits; 2^INDEX_W lines
- OFFSET_W, 4, word-offset bits; 2^OFFSET_W words per line
- Derived: TAG_W = 32-INDEX_W-OFFSET_W (20); LINE_W = 32·2^OFFSET_W (512). Addresses are word addresses: tag=addr[31:12], index=addr[11:4], offset=addr[3:0].

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock, all state on posedge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  request present
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  32  word address
- cpu_wdata  in  32  write data
- cpu_ready  out  1  combinational, =1 only in IDLE; request accepted on edge where cpu_req&cpu_ready
- cpu_valid  out  1  one-cycle completion pulse (reads and writes)
- cpu_rdata  out  32  read data, valid with cpu_valid on reads; holds previous value on writes
- cpu_hit  out  1  lookup result of the completed request, valid with cpu_valid
- mem_req, mem_we  out  1  memory access request / write
- mem_addr, mem_wdata  out  32  memory word address / write data
- mem_ack  in  1  transfer completes on edge with mem_req&mem_ack
- mem_rdata  in  32  read data, sampled on the ack edge
- arr_index  out  INDEX_W  data-array line select
- arr_offset  out  OFFSET_W  data-array word select
- arr_rdata  in  32  combinational word read of arr_index/arr_offset
- arr_wr  out  1  word write of arr_wdata at arr_index/arr_offset
- arr_wdata  out  32  word write data
- arr_fill  out  1  whole-line write of arr_fill_line at arr_index
- arr_fill_line  out  LINE_W  refill line; word k at bits [32k+31:32k]
- hit_cnt, miss_cnt  out  16  lookup statistics; wrap at 0xFFFF→0

## Operation
- States: IDLE, LOOKUP, REFILL, FILL, WRITE.
- IDLE: on accept, capture addr/we/wdata → LOOKUP.
- LOOKUP: arr_index/arr_offset from the captured address. hit = valid[index] & tag[index]==addr_tag. hit_cnt or miss_cnt increments at the LOOKUP edge.
  - Read hit: cpu_rdata←arr_rdata, cpu_hit←1, cpu_valid←1 → IDLE.
  - Read miss: word counter cnt←0 → REFILL.
  - Any write → WRITE (the hit flag is latched).
- REFILL: mem_req=1, mem_we=0, mem_addr={tag,index,cnt}.
  - Each ack edge stores mem_rdata into buffer word cnt and increments cnt.
  - Ack with cnt==15 → FILL.
  - Words are always fetched 0..15; the line is not fetched critical-word-first.
- FILL: arr_fill=1, arr_fill_line=buffer.
  - At the edge: tag[index]←addr_tag, valid[index]←1.
  - cpu_rdata←buffer[offset], cpu_hit←0, cpu_valid←1 → IDLE.
  - A valid line with a different tag is overwritten silently; there is no writeback.
- WRITE: mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=wdata.
  - On the ack edge: arr_wr=hit_q, with arr_wdata=wdata at index/offset. cpu_hit←hit_q, cpu_valid←1 → IDLE.
  - Write miss leaves tag/valid unchanged.
- mem_ack while mem_req=0 is ignored. cpu_req while cpu_ready=0 is ignored; the requester holds its request.

## Timing
- Reset: state IDLE, all valid bits 0. cpu_valid, cpu_hit, cpu_rdata, mem_*, arr_wr, arr_fill, cnt, hit_cnt, miss_cnt all 0.
- Reset in any state takes priority: refill is abandoned, no fill, no valid set, and mem_req is low in the cycle after the reset edge.
- Read hit: accept E0, LOOKUP edge E1, cpu_valid high in the cycle after E1. Minimum spacing between accepts is 2 cycles.
- Read miss with mem_ack tied high: acks at E2..E17, FILL edge E18, cpu_valid in the cycle after E18. Each stalled ack adds one cycle.
- Write: accept E0, LOOKUP E1, WRITE ack edge ≥E2, cpu_valid in the cycle after the ack.
- cpu_valid is exactly one cycle per request. mem_req stays continuously high from REFILL entry until the 16th ack.
- A read immediately following a write-hit to the same word returns the new data, because the array is updated at the ack edge.

## Test plan
- Reset, then read 0x0000_1230 with mem_rdata=0xA000_0000+word: 16 mem reads at addr 0x1230..0x123F; cpu_valid with rdata 0xA000_0000, cpu_hit=0; miss_cnt=1.
- Re-read 0x0000_1235: cpu_valid 2 cycles after accept, rdata 0xA000_0005, cpu_hit=1, no mem_req; hit_cnt=1.
- Read 0x0000_2230 (same index, new tag): full refill, cpu_hit=0; a subsequent read of 0x0000_1230 misses again.
- Write 0xDEAD_BEEF to 0x0000_2231 (hit): one mem write, arr_wr pulse on the ack edge, cpu_hit=1; a read of 0x0000_2231 hits with 0xDEAD_BEEF. Write to 0x0000_5000 (miss): mem write only, no arr_wr; a later read of it misses.
- mem_ack toggled randomly during refill: data is correct, cpu_valid is delayed by exactly the number of stall cycles, and acks while mem_req=0 have no effect.
- Assert reset at refill word 7: mem_req low the next cycle, no arr_fill; a following read to the same address misses and refills all 16 words.

Source files
------------

// File: rtl/dm_cache_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dm_cache_ctrl_if
//  Description : CPU request/response bus of the direct-mapped cache controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dm_cache_ctrl_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_valid;
    logic [31:0] cpu_rdata;
    logic        cpu_hit;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_valid, cpu_rdata, cpu_hit
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_valid, cpu_rdata, cpu_hit
    );
endinterface
`default_nettype wire

// File: rtl/dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dm_cache_ctrl
//  Description : Direct-mapped, write-through / no-write-allocate cache
//                controller with tag/valid store and full-line read refill.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_cache_ctrl #(
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4
) (
    input  wire logic                          clk,
    input  wire logic                          reset,
    dm_cache_ctrl_if.slave                     bus,
    output logic                               mem_req,
    output logic                               mem_we,
    output logic [31:0]                        mem_addr,
    output logic [31:0]                        mem_wdata,
    input  wire logic                          mem_ack,
    input  wire logic [31:0]                   mem_rdata,
    output logic [INDEX_W-1:0]                 arr_index,
    output logic [OFFSET_W-1:0]                arr_offset,
    input  wire logic [31:0]                   arr_rdata,
    output logic                               arr_wr,
    output logic [31:0]                        arr_wdata,
    output logic                               arr_fill,
    output logic [32*(2**OFFSET_W)-1:0]        arr_fill_line,
    output logic [15:0]                        hit_cnt,
    output logic [15:0]                        miss_cnt
);

    localparam int c_TAG_W = 32 - INDEX_W - OFFSET_W;
    localparam int c_LINES = 2 ** INDEX_W;
    localparam int c_WORDS = 2 ** OFFSET_W;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LOOKUP = 3'd1;
    localparam logic [2:0] c_ST_REFILL = 3'd2;
    localparam logic [2:0] c_ST_FILL   = 3'd3;
    localparam logic [2:0] c_ST_WRITE  = 3'd4;

    logic [2:0]          r_state;
    logic [31:0]         r_addr;
    logic                r_we;
    logic [31:0]         r_wdata;
    logic                r_hit;
    logic [OFFSET_W-1:0] r_cnt;
    logic [c_LINES-1:0]  r_valid;
    logic [c_TAG_W-1:0]  r_tag [0:c_LINES-1];
    logic [31:0]         r_buf [0:c_WORDS-1];
    logic                r_cpu_valid;
    logic                r_cpu_hit;
    logic [31:0]         r_cpu_rdata;
    logic [15:0]         r_hit_cnt;
    logic [15:0]         r_miss_cnt;

    logic [c_TAG_W-1:0]  w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [OFFSET_W-1:0] w_offset;
    logic                w_lookup_hit;
    logic                w_ack;
    logic                w_last;

    assign w_tag        = r_addr[31 -: c_TAG_W];
    assign w_index      = r_addr[OFFSET_W +: INDEX_W];
    assign w_offset     = r_addr[OFFSET_W-1:0];
    assign w_lookup_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_ack        = mem_req && mem_ack;
    assign w_last       = (r_cnt == {OFFSET_W{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_hit       <= 1'b0;
            r_cnt       <= '0;
            r_valid     <= '0;
            r_cpu_valid <= 1'b0;
            r_cpu_hit   <= 1'b0;
            r_cpu_rdata <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_cpu_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.cpu_req) begin
                        r_addr  <= bus.cpu_addr;
                        r_we    <= bus.cpu_we;
                        r_wdata <= bus.cpu_wdata;
                        r_state <= c_ST_LOOKUP;
                    end
                end
                c_ST_LOOKUP: begin
                    r_hit <= w_lookup_hit;
                    if (w_lookup_hit) r_hit_cnt  <= r_hit_cnt + 16'd1;
                    else              r_miss_cnt <= r_miss_cnt + 16'd1;
                    if (r_we) begin
                        r_state <= c_ST_WRITE;
                    end else if (w_lookup_hit) begin
                        r_cpu_rdata <= arr_rdata;
                        r_cpu_hit   <= 1'b1;
                        r_cpu_valid <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= c_ST_REFILL;
                    end
                end
                c_ST_REFILL: begin
                    if (w_ack) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) r_state <= c_ST_FILL;
                    end
                end
                c_ST_FILL: begin
                    r_valid[w_index] <= 1'b1;
                    r_cpu_rdata      <= r_buf[w_offset];
                    r_cpu_hit        <= 1'b0;
                    r_cpu_valid      <= 1'b1;
                    r_state          <= c_ST_IDLE;
                end
                c_ST_WRITE: begin
                    if (w_ack) begin
                        r_cpu_hit   <= r_hit;
                        r_cpu_valid <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Storage without reset; gating on reset lets an abandoned refill leave no trace.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == c_ST_REFILL && w_ack) r_buf[r_cnt] <= mem_rdata;
            if (r_state == c_ST_FILL) r_tag[w_index] <= w_tag;
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        arr_wr    = 1'b0;
        arr_fill  = 1'b0;
        case (r_state)
            c_ST_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {w_tag, w_index, r_cnt};
            end
            c_ST_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                arr_wr    = mem_ack && r_hit;
            end
            c_ST_FILL: arr_fill = 1'b1;
            default: ;
        endcase
    end

    for (genvar k = 0; k < c_WORDS; k++) begin : g_fill_pack
        assign arr_fill_line[32*k +: 32] = r_buf[k];
    end

    assign arr_index     = w_index;
    assign arr_offset    = w_offset;
    assign arr_wdata     = r_wdata;
    assign bus.cpu_ready = (r_state == c_ST_IDLE);
    assign bus.cpu_valid = r_cpu_valid;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.cpu_hit   = r_cpu_hit;
    assign hit_cnt       = r_hit_cnt;
    assign miss_cnt      = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_cache_ctrl
//  Description : Directed bench for dm_cache_ctrl with memory and data-array models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_cache_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dm_cache_ctrl_if bus();

    logic         mem_req, mem_we, mem_ack;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;
    logic [7:0]   arr_index;
    logic [3:0]   arr_offset;
    logic [31:0]  arr_rdata, arr_wdata;
    logic         arr_wr, arr_fill;
    logic [511:0] arr_fill_line;
    logic [15:0]  hit_cnt, miss_cnt;

    dm_cache_ctrl #(.INDEX_W(8), .OFFSET_W(4)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .arr_index     (arr_index),
        .arr_offset    (arr_offset),
        .arr_rdata     (arr_rdata),
        .arr_wr        (arr_wr),
        .arr_wdata     (arr_wdata),
        .arr_fill      (arr_fill),
        .arr_fill_line (arr_fill_line),
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
    );

    // Main memory: word k of any line reads as membase + k.
    logic [31:0] membase = 32'hA000_0000;
    logic        ack_rand = 1'b0;
    assign mem_rdata = membase + {28'd0, mem_addr[3:0]};
    always @(negedge clk) mem_ack = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;

    // Data array model.
    logic [511:0] arr_mem [0:255];
    assign arr_rdata = arr_mem[arr_index][32*arr_offset +: 32];
    always @(posedge clk) begin
        if (arr_fill) arr_mem[arr_index] <= arr_fill_line;
        if (arr_wr) arr_mem[arr_index][32*arr_offset +: 32] <= arr_wdata;
    end

    // Bus activity recorder.
    int          n_memrd = 0, n_memwr = 0, n_arrwr = 0, n_fill = 0, n_stall = 0;
    logic [31:0] rd_addr [0:255];
    logic [31:0] wr_addr_last = '0, wr_data_last = '0;
    always @(posedge clk) begin
        if (mem_req && mem_ack && !mem_we) begin
            rd_addr[n_memrd % 256] <= mem_addr;
            n_memrd <= n_memrd + 1;
        end
        if (mem_req && mem_ack && mem_we) begin
            wr_addr_last <= mem_addr;
            wr_data_last <= mem_wdata;
            n_memwr <= n_memwr + 1;
        end
        if (mem_req && !mem_we && !mem_ack) n_stall <= n_stall + 1;
        if (arr_wr) n_arrwr <= n_arrwr + 1;
        if (arr_fill) n_fill <= n_fill + 1;
    end

    int n_cmp = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] res_rdata;
    logic        res_hit;
    int          res_lat;
    logic        res_got;

    // Issue one request; res_lat counts edges from the accept edge to the sample showing cpu_valid.
    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        n = 0;
        while (!bus.cpu_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        res_lat = 0; res_got = 1'b0;
        for (int i = 0; i < 300 && !res_got; i++) begin
            @(posedge clk); #1;
            res_lat++;
            if (bus.cpu_valid) res_got = 1'b1;
        end
        res_rdata = bus.cpu_rdata;
        res_hit   = bus.cpu_hit;
        check("valid_seen", 32'(res_got), 32'd1);
        if (res_got) begin
            @(posedge clk); #1;
            check("valid_one_cycle", 32'(bus.cpu_valid), 32'd0);
        end
    endtask

    task automatic check_line_reads(input string tag, input int start, input logic [31:0] base);
        check({tag, "_nreads"}, 32'(n_memrd - start), 32'd16);
        for (int k = 0; k < 16; k++)
            check({tag, "_raddr"}, rd_addr[(start + k) % 256], base + 32'(k));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_rd, s_wr, s_aw, s_fill, s_stall;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        #1;
        check("rst_ready", 32'(bus.cpu_ready), 32'd1);
        check("rst_valid", 32'(bus.cpu_valid), 32'd0);
        check("rst_hit", 32'(bus.cpu_hit), 32'd0);
        check("rst_rdata", bus.cpu_rdata, 32'd0);
        check("rst_memreq", 32'(mem_req), 32'd0);
        check("rst_memaddr", mem_addr, 32'd0);
        check("rst_arr", {30'd0, arr_wr, arr_fill}, 32'd0);
        check("rst_cnts", {hit_cnt, miss_cnt}, 32'd0);

        // Cold read miss.
        membase = 32'hA000_0000; s_rd = n_memrd; s_fill = n_fill;
        do_req(1'b0, 32'h0000_1230, '0);
        check("miss1_rdata", res_rdata, 32'hA000_0000);
        check("miss1_hit", 32'(res_hit), 32'd0);
        check("miss1_lat", 32'(res_lat), 32'd18);
        check("miss1_misscnt", 32'(miss_cnt), 32'd1);
        check("miss1_fill", 32'(n_fill - s_fill), 32'd1);
        check_line_reads("miss1", s_rd, 32'h0000_1230);

        // Read hit on the freshly filled line.
        s_rd = n_memrd;
        do_req(1'b0, 32'h0000_1235, '0);
        check("hit1_rdata", res_rdata, 32'hA000_0005);
        check("hit1_hit", 32'(res_hit), 32'd1);
        check("hit1_lat", 32'(res_lat), 32'd1);
        check("hit1_nomem", 32'(n_memrd - s_rd), 32'd0);
        check("hit1_hitcnt", 32'(hit_cnt), 32'd1);

        // Conflict miss, same index new tag.
        membase = 32'hB000_0000; s_rd = n_memrd;
        do_req(1'b0, 32'h0000_2230, '0);
        check("conf_rdata", res_rdata, 32'hB000_0000);
        check("conf_hit", 32'(res_hit), 32'd0);
        check("conf_misscnt", 32'(miss_cnt), 32'd2);
        check_line_reads("conf", s_rd, 32'h0000_2230);

        // Write hit, then read back the written word.
        s_wr = n_memwr; s_aw = n_arrwr;
        do_req(1'b1, 32'h0000_2231, 32'hDEAD_BEEF);
        check("wh_hit", 32'(res_hit), 32'd1);
        check("wh_lat", 32'(res_lat), 32'd2);
        check("wh_nmemwr", 32'(n_memwr - s_wr), 32'd1);
        check("wh_narrwr", 32'(n_arrwr - s_aw), 32'd1);
        check("wh_waddr", wr_addr_last, 32'h0000_2231);
        check("wh_wdata", wr_data_last, 32'hDEAD_BEEF);
        check("wh_hitcnt", 32'(hit_cnt), 32'd2);
        do_req(1'b0, 32'h0000_2231, '0);
        check("wh_rd_rdata", res_rdata, 32'hDEAD_BEEF);
        check("wh_rd_hit", 32'(res_hit), 32'd1);
        check("wh_rd_hitcnt", 32'(hit_cnt), 32'd3);

        // Old tag was evicted.
        membase = 32'hA000_0000;
        do_req(1'b0, 32'h0000_1230, '0);
        check("evict_hit", 32'(res_hit), 32'd0);
        check("evict_rdata", res_rdata, 32'hA000_0000);
        check("evict_misscnt", 32'(miss_cnt), 32'd3);

        // Write miss: memory only, no allocate.
        s_wr = n_memwr; s_aw = n_arrwr;
        do_req(1'b1, 32'h0000_5000, 32'h1234_5678);
        check("wm_hit", 32'(res_hit), 32'd0);
        check("wm_nmemwr", 32'(n_memwr - s_wr), 32'd1);
        check("wm_narrwr", 32'(n_arrwr - s_aw), 32'd0);
        check("wm_waddr", wr_addr_last, 32'h0000_5000);
        check("wm_misscnt", 32'(miss_cnt), 32'd4);
        membase = 32'hC000_0000;
        do_req(1'b0, 32'h0000_5000, '0);
        check("wm_rd_hit", 32'(res_hit), 32'd0);
        check("wm_rd_rdata", res_rdata, 32'hC000_0000);
        check("wm_rd_misscnt", 32'(miss_cnt), 32'd5);

        // Refill with randomly stalled acks.
        membase = 32'hD000_0000; ack_rand = 1'b1; s_rd = n_memrd; s_stall = n_stall;
        do_req(1'b0, 32'h0000_6A4C, '0);
        check("stall_rdata", res_rdata, 32'hD000_000C);
        check("stall_hit", 32'(res_hit), 32'd0);
        check("stall_lat", 32'(res_lat), 32'(18 + (n_stall - s_stall)));
        check_line_reads("stall", s_rd, 32'h0000_6A40);
        ack_rand = 1'b0;
        do_req(1'b0, 32'h0000_6A47, '0);
        check("stall_hit2_rdata", res_rdata, 32'hD000_0007);
        check("stall_hit2_hit", 32'(res_hit), 32'd1);
        check("stall_hitcnt", 32'(hit_cnt), 32'd4);

        // Reset in the middle of a refill.
        membase = 32'hE000_0000; s_rd = n_memrd; s_fill = n_fill;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_7340;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        for (int i = 0; i < 100 && (n_memrd - s_rd) < 7; i++) begin @(posedge clk); #1; end
        check("rstmid_reads", 32'(n_memrd - s_rd), 32'd7);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("rstmid_memreq", 32'(mem_req), 32'd0);
        @(negedge clk); reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rstmid_nofill", 32'(n_fill - s_fill), 32'd0);
        check("rstmid_ready", 32'(bus.cpu_ready), 32'd1);
        check("rstmid_cnts", {hit_cnt, miss_cnt}, 32'd0);
        s_rd = n_memrd;
        do_req(1'b0, 32'h0000_7340, '0);
        check("rstmid_hit", 32'(res_hit), 32'd0);
        check("rstmid_rdata", res_rdata, 32'hE000_0000);
        check("rstmid_misscnt", 32'(miss_cnt), 32'd1);
        check_line_reads("rstmid", s_rd, 32'h0000_7340);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
